// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions.
// Divider state encodings and datapath width constants.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;
   localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step.
// Shift {rem, quo} left, then trial-subtract the divisor.
module div_step
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor_mag,
   output logic [WIDTH-1:0] rem_nx,
   output logic [WIDTH-1:0] quo_nx
);

   logic [WIDTH:0] sh;
   logic [WIDTH:0] trial;
   logic           ge;

   // A set top bit means the shifted value already exceeds any divisor.
   always_comb begin
      sh     = {rem, quo[WIDTH-1]};
      trial  = sh - {1'b0, divisor_mag};
      ge     = sh[WIDTH] | ~trial[WIDTH];
      rem_nx = ge ? trial[WIDTH-1:0] : sh[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], ge};
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: quotient to lo, remainder to hi.
// Magnitude restoring division with sign fix-up in a final cycle.
module div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CW = $clog2(WIDTH);

   div_state_e state, state_nx;

   logic [CW-1:0]    cnt;
   logic             sgn;
   logic             dvd_neg;
   logic             dvs_neg;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH-1:0] dvd_raw;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_in_mag;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem         (rem),
      .quo         (quo),
      .divisor_mag (dvs_mag),
      .rem_nx      (rem_nx),
      .quo_nx      (quo_nx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= DIV_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         DIV_IDLE: if (start) state_nx = DIV_CALC;
         DIV_CALC: if (cnt == CW'(WIDTH-1)) state_nx = DIV_FIX;
         DIV_FIX:  state_nx = DIV_IDLE;
         default:  state_nx = DIV_IDLE;
      endcase
   end

   assign busy = (state != DIV_IDLE);

   always_comb begin
      dvd_mag    = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
      dvs_in_mag = (is_signed & divisor[WIDTH-1])  ? -divisor  : divisor;
      q_fix      = (sgn & (dvd_neg ^ dvs_neg)) ? -quo : quo;
      r_fix      = (sgn & dvd_neg) ? -rem : rem;
      // Divide by zero overrides the arithmetic result.
      if (dvs_mag == '0) begin
         q_fix = '1;
         r_fix = dvd_raw;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         sgn     <= 1'b0;
         dvd_neg <= 1'b0;
         dvs_neg <= 1'b0;
         dvs_mag <= '0;
         dvd_raw <= '0;
         rem     <= '0;
         quo     <= '0;
         lo      <= '0;
         hi      <= '0;
      end else begin
         unique case (state)
            DIV_IDLE: if (start) begin
               sgn     <= is_signed;
               dvd_neg <= is_signed & dividend[WIDTH-1];
               dvs_neg <= is_signed & divisor[WIDTH-1];
               dvs_mag <= dvs_in_mag;
               dvd_raw <= dividend;
               rem     <= '0;
               quo     <= dvd_mag;
               cnt     <= '0;
            end
            DIV_CALC: begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt + CW'(1);
            end
            DIV_FIX: begin
               lo <= q_fix;
               hi <= r_fix;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider answering the controller's `div_start` / `div_signed` / `div_busy` handshake. It executes MIPS `DIV` and `DIVU`:
- quotient → LO
- remainder → HI

Each operation is a fixed-latency radix-2 restoring division. The controller stalls its microstep sequence while `busy` is high, then latches `lo`/`hi` into the LO/HI registers.

## Interface
- `WIDTH`, 32, operand/result width; the iteration count equals `WIDTH`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  one-cycle request pulse (controller `div_start`).
- `is_signed`  in  1  1 = DIV, 0 = DIVU (controller `div_signed`); sampled together with `start`.
- `dividend`  in  WIDTH  rs value; sampled together with `start`.
- `divisor`  in  WIDTH  rt value; sampled together with `start`.
- `busy`  out  1  high while an operation is in progress (controller `div_busy`).
- `lo`  out  WIDTH  quotient, registered.
- `hi`  out  WIDTH  remainder, registered.

## Operation
- States: IDLE, CALC, FIX. `busy` = (state != IDLE).
- **IDLE, `start`=1:**
  - Capture `is_signed`.
  - Capture the dividend/divisor signs when signed.
  - Capture the magnitudes: two's-complement negate when signed and negative; raw values otherwise.
  - Clear the partial remainder. Load the dividend magnitude into the quotient shift register. Counter ← 0. Go to CALC.
- **CALC, one step per cycle:**
  - {rem, quo} shifted left 1.
  - trial = rem − divisor_mag, computed WIDTH+1 bits wide.
  - If trial ≥ 0: rem ← trial, quo[0] ← 1. Else quo[0] ← 0.
  - Counter increments. After step `WIDTH`−1, go to FIX.
- **FIX:**
  - Signed case: quotient is negated if the dividend sign XOR divisor sign is 1. Remainder is negated if the dividend sign is 1, so the remainder takes the dividend's sign.
  - Write `lo`/`hi`. Go to IDLE.
- **Divide by zero:** FIX forces `lo` = all ones and `hi` = raw dividend, signed or unsigned. Latency is unchanged.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives `lo` = 0x80000000, `hi` = 0. This falls out of the magnitude path and needs no special case.
- `start` while busy is ignored. No queueing; operands are not re-sampled.
- `lo`/`hi` hold their value from the end of FIX until the next FIX. They do not change during CALC.
- **`rst`=0 at any time:** state IDLE, `busy` 0, `lo`/`hi` 0, counter 0, all internal registers 0. This holds immediately and asynchronously, including mid-CALC. After release, the unit accepts `start` on the next rising edge.

## Timing
- Reset values: `busy`=0, `lo`=0, `hi`=0.
- `start` is sampled at edge N.
- `busy` rises after edge N and stays high for `WIDTH`+1 cycles:
  - `WIDTH` CALC cycles.
  - 1 FIX cycle.
- For `WIDTH`=32: `lo`/`hi` update and `busy` falls after edge N+33.
- The controller samples `busy`=0 and reads `lo`/`hi` in the same cycle; the results are stable from that point.
- A new `start` is accepted at edge N+34 at the earliest, i.e. the first edge with state IDLE.
- The trial subtraction is combinational within one cycle. This is a single WIDTH+1-bit adder on the critical path.

## Structure
- Shared package `mdu_pkg`:
  - `DIV_IDLE`, `DIV_CALC`, `DIV_FIX` state encodings (2-bit).
  - `MDU_WIDTH` = 32.
  - Iteration-counter width `$clog2(MDU_WIDTH)`.
  - These are shared with the multiplier block.
- One natural sub-module, `div_step`:
  - Combinational.
  - Inputs: rem, quo, divisor_mag.
  - Outputs: next rem, next quo.
  - Instantiated once in `div_unit`; FSM, counter, sign handling and output registers remain in the top.

## Test plan
- **Unsigned, basic:** DIVU 100 / 7 with `start` pulse → `busy` high exactly 33 cycles; then `lo`=14, `hi`=2, held until the next operation.
- **Signed, mixed signs:**
  - DIV 0xFFFFFFF9 (−7) / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 7 / 0xFFFFFFFE → `lo`=0xFFFFFFFD, `hi`=1.
- **Boundaries:**
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - DIVU with the same operands → `lo`=0, `hi`=0x80000000.
- **Divide by zero:** DIVU 5 / 0 and DIV 0xFFFFFFFB / 0 → `lo`=0xFFFFFFFF, `hi`=dividend; `busy` still 33 cycles.
- **Start while busy:** pulse `start` with new operands at busy cycle 10 → ignored; original result delivered at cycle 33.
- **Reset mid-operation:** assert `rst`=0 at busy cycle 10 → `busy`, `lo`, `hi` = 0 immediately. After release, DIVU 9 / 3 → `lo`=3, `hi`=0 after 33 cycles.
